// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Counter width able to hold the value TIMEOUT_CYCLES itself.
    function automatic int timeout_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Busy-cycle counter for the arbiter: counts while enabled, cleared on
// demand, and flags the cycle in which the count reaches TIMEOUT_CYCLES.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The increment in this cycle brings the count to TIMEOUT_CYCLES.
    assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data port.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// ties; otherwise the data port wins every tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_ack,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    input  logic                  i_dm_req,
    input  logic                  i_dm_we,
    input  logic [ADDR_WIDTH-1:0] i_dm_addr,
    input  logic [DATA_WIDTH-1:0] i_dm_wdata,
    output logic                  o_dm_ack,
    output logic [DATA_WIDTH-1:0] o_dm_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_err
);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  abort_q, abort_d;
    logic                  cnt_clr, cnt_en, expired;
    logic                  any_req;
    owner_t                tie_win, win;

    assign any_req = i_if_req || i_dm_req;

`ifdef MEM_ARB_RR_EN
    owner_t last_q;

    // Remember who was granted last so a tie goes to the other requester.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= OWN_IF;
        end else if (state_q == IDLE && any_req) begin
            last_q <= win;
        end
    end

    assign tie_win = (last_q == OWN_DM) ? OWN_IF : OWN_DM;
`else
    assign tie_win = OWN_DM;
`endif

    // Winner selection for the current IDLE cycle.
    always_comb begin
        win = OWN_DM;
        if (i_if_req && i_dm_req) begin
            win = tie_win;
        end else if (i_if_req) begin
            win = OWN_IF;
        end
    end

    // Next-state and datapath latching for the grant/busy/response cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = win;
                    state_d = BUSY;
                    if (win == OWN_IF) begin
                        addr_d  = i_if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end else begin
                        addr_d  = i_dm_addr;
                        we_d    = i_dm_we;
                        wdata_d = i_dm_wdata;
                    end
                end
            end
            BUSY: begin
                cnt_en = 1'b1;
                if (i_mem_ack) begin
                    rdata_d = i_mem_rdata;
                    state_d = RESP;
                end else if (expired) begin
                    abort_d = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_clr = 1'b1;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and payload registers; reset drops any in-flight transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
        end
    end

    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expired_o(expired)
    );

    // Outputs decode only registered state, never live inputs.
    assign o_mem_req   = (state_q == BUSY);
    assign o_mem_we    = o_mem_req && we_q;
    assign o_mem_addr  = o_mem_req ? addr_q  : '0;
    assign o_mem_wdata = o_mem_req ? wdata_q : '0;

    assign o_if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
    assign o_dm_ack    = (state_q == RESP) && (owner_q == OWN_DM);
    assign o_if_rdata  = o_if_ack ? rdata_q : '0;
    assign o_dm_rdata  = o_dm_ack ? rdata_q : '0;
    assign o_err       = (state_q == RESP) && abort_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default and short-timeout instances).
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        if_ack, dm_ack, mem_req, mem_we, err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        t_dm_req, t_mem_ack;
    logic        t_if_ack, t_dm_ack, t_mem_req, t_mem_we, t_err;
    logic [31:0] t_if_rdata, t_dm_rdata, t_mem_addr, t_mem_wdata;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_err(err)
    );

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_to (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(1'b0), .i_if_addr(if_addr), .o_if_ack(t_if_ack), .o_if_rdata(t_if_rdata),
        .i_dm_req(t_dm_req), .i_dm_we(1'b0), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_ack(t_dm_ack), .o_dm_rdata(t_dm_rdata),
        .o_mem_req(t_mem_req), .o_mem_we(t_mem_we), .o_mem_addr(t_mem_addr), .o_mem_wdata(t_mem_wdata),
        .i_mem_ack(t_mem_ack), .i_mem_rdata(mem_rdata), .o_err(t_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".mem_req"},   mem_req,   0);
        chk({tag, ".mem_we"},    mem_we,    0);
        chk({tag, ".mem_addr"},  mem_addr,  0);
        chk({tag, ".mem_wdata"}, mem_wdata, 0);
        chk({tag, ".if_ack"},    if_ack,    0);
        chk({tag, ".if_rdata"},  if_rdata,  0);
        chk({tag, ".dm_ack"},    dm_ack,    0);
        chk({tag, ".dm_rdata"},  dm_rdata,  0);
        chk({tag, ".err"},       err,       0);
    endtask

    initial begin
        logic [31:0] exp_addr;

        rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
        dm_wdata = 0; mem_ack = 0; mem_rdata = 0; t_dm_req = 0; t_mem_ack = 0;
        step();
        step();
        chk_quiet("reset");
        chk("reset.t_mem_req", t_mem_req, 0);
        chk("reset.t_dm_ack", t_dm_ack, 0);
        rst = 1'b0;

        // memory ack outside BUSY is ignored
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        step();
        chk_quiet("idle_ack");
        mem_ack = 0;

        // fetch read
        if_req = 1; if_addr = 32'h100;
        step();
        chk("fetch.mem_req", mem_req, 1);
        chk("fetch.mem_addr", mem_addr, 32'h100);
        chk("fetch.mem_we", mem_we, 0);
        chk("fetch.dm_ack_busy", dm_ack, 0);
        chk("fetch.if_ack_busy", if_ack, 0);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("fetch.if_ack", if_ack, 1);
        chk("fetch.if_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("fetch.dm_ack", dm_ack, 0);
        chk("fetch.dm_rdata", dm_rdata, 0);
        chk("fetch.err", err, 0);
        chk("fetch.mem_req_resp", mem_req, 0);
        if_req = 0; mem_ack = 0;
        step();
        chk("fetch.if_ack_done", if_ack, 0);

        // tie: data write first, then fetch
        rst = 1; step(); rst = 0;
        dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'h55AA;
        if_req = 1; if_addr = 32'h104;
        step();
        chk("tie.first_we", mem_we, 1);
        chk("tie.first_addr", mem_addr, 32'h20);
        chk("tie.first_wdata", mem_wdata, 32'h55AA);
        mem_ack = 1; mem_rdata = 32'h1234;
        step();
        chk("tie.dm_ack", dm_ack, 1);
        chk("tie.dm_rdata", dm_rdata, 32'h1234);
        chk("tie.if_ack_during_dm", if_ack, 0);
        dm_req = 0; dm_we = 0; mem_ack = 0;
        step();
        step();
        chk("tie.second_req", mem_req, 1);
        chk("tie.second_addr", mem_addr, 32'h104);
        chk("tie.second_we", mem_we, 0);
        chk("tie.second_wdata", mem_wdata, 0);
        mem_ack = 1; mem_rdata = 32'hCAFE;
        step();
        chk("tie.if_ack", if_ack, 1);
        chk("tie.if_rdata", if_rdata, 32'hCAFE);
        chk("tie.dm_ack_during_if", dm_ack, 0);
        if_req = 0; mem_ack = 0;
        step();

        // continuous contention over 10 transactions
        rst = 1; step(); rst = 0;
        dm_req = 1; dm_addr = 32'h300; if_req = 1; if_addr = 32'h400;
        mem_ack = 1; mem_rdata = 32'h5A5A;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_addr = (i % 2 == 0) ? 32'h300 : 32'h400;
`else
            exp_addr = 32'h300;
`endif
            step();
            chk($sformatf("contend%0d.addr", i), mem_addr, exp_addr);
            step();
            chk($sformatf("contend%0d.dm_ack", i), dm_ack, (exp_addr == 32'h300) ? 1 : 0);
            chk($sformatf("contend%0d.if_ack", i), if_ack, (exp_addr == 32'h400) ? 1 : 0);
            step();
        end
        dm_req = 0; if_req = 0; mem_ack = 0;
        step();
        step();

        // wait states: ack delayed 5 cycles, address held stable
        dm_req = 1; dm_we = 0; dm_addr = 32'h500; dm_wdata = 32'h0;
        step();
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("wait%0d.mem_req", i), mem_req, 1);
            chk($sformatf("wait%0d.addr", i), mem_addr, 32'h500);
            chk($sformatf("wait%0d.dm_ack", i), dm_ack, 0);
            if (i == 6) begin
                mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
            end
            step();
        end
        chk("wait.dm_ack", dm_ack, 1);
        chk("wait.dm_rdata", dm_rdata, 32'h0BAD_F00D);
        dm_req = 0; mem_ack = 0;
        step();

        // payload change while busy is ignored
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hA5;
        step();
        chk("payload.addr0", mem_addr, 32'h40);
        dm_addr = 32'h44; dm_wdata = 32'h5A; dm_we = 0;
        step();
        chk("payload.addr1", mem_addr, 32'h40);
        chk("payload.wdata1", mem_wdata, 32'hA5);
        chk("payload.we1", mem_we, 1);
        mem_ack = 1;
        step();
        chk("payload.dm_ack", dm_ack, 1);
        dm_req = 0; mem_ack = 0;
        step();

        // reset in BUSY drops the transaction
        dm_req = 1; dm_we = 0; dm_addr = 32'h60;
        step();
        chk("rstmid.busy", mem_req, 1);
        rst = 1; dm_req = 0;
        step();
        chk_quiet("rstmid");
        rst = 0; mem_ack = 1; mem_rdata = 32'h9999;
        step();
        chk("rstmid.no_ack0", dm_ack, 0);
        step();
        chk("rstmid.no_ack1", dm_ack, 0);
        mem_ack = 0;
        if_req = 1; if_addr = 32'h80;
        step();
        chk("rstmid.new_req", mem_req, 1);
        mem_ack = 1; mem_rdata = 32'h77;
        step();
        chk("rstmid.new_ack", if_ack, 1);
        chk("rstmid.new_rdata", if_rdata, 32'h77);
        if_req = 0; mem_ack = 0;
        step();

        // timeout on the 4-cycle instance
        mem_rdata = 32'hBAD0_BAD0; dm_addr = 32'h90;
        t_dm_req = 1;
        step();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("timeout%0d.mem_req", i), t_mem_req, 1);
            chk($sformatf("timeout%0d.dm_ack", i), t_dm_ack, 0);
            step();
        end
        chk("timeout.mem_req_off", t_mem_req, 0);
        chk("timeout.dm_ack", t_dm_ack, 1);
        chk("timeout.err", t_err, 1);
        chk("timeout.dm_rdata", t_dm_rdata, 0);
        t_dm_req = 0;
        step();
        chk("timeout.err_clear", t_err, 0);
        t_dm_req = 1; dm_addr = 32'h94;
        step();
        chk("timeout.next_addr", t_mem_addr, 32'h94);
        t_mem_ack = 1;
        step();
        chk("timeout.next_ack", t_dm_ack, 1);
        chk("timeout.next_err", t_err, 0);
        chk("timeout.next_rdata", t_dm_rdata, 32'hBAD0_BAD0);
        t_dm_req = 0; t_mem_ack = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
